// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bus_bridge
//  Description : Serial-to-bus master. Pulls command bytes from the UART data
//                register, performs 32-bit reads/writes on a valid/ready
//                memory bus and returns response bytes through the same
//                register. Lets a host peek/poke memory without a CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_bridge #(
  parameter logic [31:0] RX_TIMEOUT  = 32'd1_000_000,
  parameter logic [15:0] BUS_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        uart_dat_we,
  output logic        uart_dat_re,
  output logic [31:0] uart_dat_di,
  input  logic [31:0] uart_dat_do,
  input  logic        uart_dat_wait,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0]  C_CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0]  C_CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0]  C_RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0]  C_RSP_BAD   = 8'h3F;  // '?'
  localparam logic [7:0]  C_RSP_ERR   = 8'h45;  // 'E'
  localparam logic [31:0] C_RX_EMPTY  = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;       // command kind: 1 = write, 0 = read
  logic [1:0]  cnt_q, cnt_d;           // byte index within addr/data field
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;         // response bytes still to send, MSB next
  logic [1:0]  remain_q, remain_d;     // bytes left after the one on the wire
  logic [31:0] rx_cnt_q, rx_cnt_d;     // idle clocks between command bytes
  logic [15:0] bus_cnt_q, bus_cnt_d;   // clocks spent waiting for mem_ready
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic        w_byte_avail;
  logic [7:0]  w_rx_byte;
  logic        w_rx_expire;
  logic        w_bus_expire;

  assign w_byte_avail = (uart_dat_do != C_RX_EMPTY);
  assign w_rx_byte    = uart_dat_do[7:0];
  assign w_rx_expire  = (rx_cnt_q >= RX_TIMEOUT - 32'd1);
  assign w_bus_expire = (bus_cnt_q >= BUS_TIMEOUT - 16'd1);

  assign uart_dat_re = re_q;
  assign uart_dat_we = we_q;
  assign uart_dat_di = {24'h0, tx_byte_q};
  assign mem_valid   = valid_q;
  assign mem_addr    = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = (valid_q && is_wr_q) ? 4'hF : 4'h0;

  // Next-state logic: a byte is consumed on the edge that closes the re_q
  // cycle, so re_q doubles as the "byte taken" indication.
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    remain_d  = remain_q;
    rx_cnt_d  = rx_cnt_q;
    bus_cnt_d = bus_cnt_q;
    re_d      = 1'b0;
    we_d      = we_q;
    valid_d   = valid_q;
    tx_byte_d = tx_byte_q;

    case (state_q)
      S_IDLE: begin
        re_d = w_byte_avail && !re_q;
        if (re_q) begin
          if (w_rx_byte == C_CMD_WRITE || w_rx_byte == C_CMD_READ) begin
            is_wr_d  = (w_rx_byte == C_CMD_WRITE);
            cnt_d    = 2'd0;
            rx_cnt_d = 32'd0;
            state_d  = S_ADDR;
          end else begin
            tx_byte_d = C_RSP_BAD;
            remain_d  = 2'd0;
            we_d      = 1'b1;
            state_d   = S_RESP;
          end
        end
      end

      S_ADDR, S_DATA: begin
        // No new read is issued on the clock the parser gives up.
        re_d = w_byte_avail && !re_q && !w_rx_expire;
        if (re_q) begin
          rx_cnt_d = 32'd0;
          cnt_d    = cnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            addr_d = {addr_q[23:0], w_rx_byte};
          end else begin
            wdata_d = {wdata_q[23:0], w_rx_byte};
          end
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && is_wr_q) begin
              state_d = S_DATA;
            end else begin
              valid_d   = 1'b1;
              bus_cnt_d = 16'd0;
              state_d   = S_BUS;
            end
          end
        end else if (w_rx_expire) begin
          state_d = S_IDLE;
        end else if (rx_cnt_q != 32'hFFFF_FFFF) begin
          rx_cnt_d = rx_cnt_q + 32'd1;
        end
      end

      S_BUS: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          we_d    = 1'b1;
          state_d = S_RESP;
          if (is_wr_q) begin
            tx_byte_d = C_RSP_OK;
            remain_d  = 2'd0;
          end else begin
            tx_byte_d = mem_rdata[31:24];
            resp_d    = {mem_rdata[23:0], 8'h00};
            remain_d  = 2'd3;
          end
        end else if (w_bus_expire) begin
          valid_d   = 1'b0;
          we_d      = 1'b1;
          tx_byte_d = C_RSP_ERR;
          remain_d  = 2'd0;
          state_d   = S_RESP;
        end else if (bus_cnt_q != 16'hFFFF) begin
          bus_cnt_d = bus_cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        // we_q is held high throughout; a byte retires only when not waited.
        if (!uart_dat_wait) begin
          if (remain_q == 2'd0) begin
            we_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            tx_byte_d = resp_q[31:24];
            resp_d    = {resp_q[23:0], 8'h00};
            remain_d  = remain_q - 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, aborting any bus
  // request or pending response on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      resp_q    <= 32'd0;
      remain_q  <= 2'd0;
      rx_cnt_q  <= 32'd0;
      bus_cnt_q <= 16'd0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      tx_byte_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      remain_q  <= remain_d;
      rx_cnt_q  <= rx_cnt_d;
      bus_cnt_q <= bus_cnt_d;
      re_q      <= re_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      tx_byte_q <= tx_byte_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_bus_bridge
//  Description : Directed self-checking bench for uart_bus_bridge with a
//                byte-queue UART model and a delayed-ready memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_bridge;

  localparam logic [31:0] RX_TO = 32'd300;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_dat_we, uart_dat_re, uart_dat_wait;
  logic [31:0] uart_dat_di, uart_dat_do;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  // UART model state
  logic [7:0] rx_mem [0:255];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic [7:0] tx_log [0:255];
  int         tx_n = 0;

  // Bus slave / monitor state
  bit          slave_en = 1'b1;
  int          slave_delay = 2;
  int          slv_cnt = 0;
  int          txn_n = 0;
  int          valid_cycles = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic        valid_prev = 1'b0, re_prev = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  int          overlap_err = 0, re_consec_err = 0, re_empty_err = 0, stab_err = 0;

  uart_bus_bridge #(.RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(16'd1024)) dut (
    .clk(clk), .reset(reset),
    .uart_dat_we(uart_dat_we), .uart_dat_re(uart_dat_re),
    .uart_dat_di(uart_dat_di), .uart_dat_do(uart_dat_do),
    .uart_dat_wait(uart_dat_wait),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign uart_dat_do = (rx_rd == rx_wr) ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd[7:0]]};

  // UART and bus-slave model plus protocol monitors
  always @(posedge clk) begin
    if (uart_dat_re === 1'b1) begin
      if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
      else re_empty_err <= re_empty_err + 1;
    end
    if (uart_dat_re === 1'b1 && uart_dat_we === 1'b1) overlap_err <= overlap_err + 1;
    if (uart_dat_re === 1'b1 && re_prev === 1'b1) re_consec_err <= re_consec_err + 1;
    re_prev <= uart_dat_re;
    if (uart_dat_we === 1'b1 && uart_dat_wait === 1'b0) begin
      tx_log[tx_n[7:0]] <= uart_dat_di[7:0];
      tx_n <= tx_n + 1;
    end
    if (mem_valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (mem_valid === 1'b1 && valid_prev === 1'b1 &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wstrb !== prev_wstrb))
      stab_err <= stab_err + 1;
    valid_prev <= mem_valid;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_wstrb <= mem_wstrb;
    if (mem_valid === 1'b1 && mem_ready) begin
      txn_n      <= txn_n + 1;
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
      last_wstrb <= mem_wstrb;
    end
    if (mem_valid === 1'b1 && !mem_ready) begin
      slv_cnt   <= slv_cnt + 1;
      mem_ready <= slave_en && (slv_cnt + 1 >= slave_delay);
    end else begin
      slv_cnt   <= 0;
      mem_ready <= 1'b0;
    end
  end

  task automatic feed_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_mem[rx_wr[7:0]] = v[8*(n-1-i) +: 8];
      rx_wr = rx_wr + 1;
    end
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_n >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_dat_wait = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({uart_dat_we, uart_dat_re, mem_valid, mem_wstrb} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0", {uart_dat_we, uart_dat_re, mem_valid, mem_wstrb});
    end
    vectors++;
    if ({uart_dat_di, mem_addr, mem_wdata} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", {uart_dat_di, mem_addr, mem_wdata});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int t0 = txn_n, x0 = tx_n, v0 = valid_cycles;
    bit ok;
    slave_delay = 2;
    feed_bytes(72'h57_00_00_10_04_DE_AD_BE_EF, 9);
    wait_tx(x0 + 1, 500, ok);
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || tx_n - x0 != 1) begin miscompares++; $display("FAIL write_resp_count: got %0d expected 1", tx_n - x0); end
    vectors++;
    if (tx_log[x0[7:0]] !== 8'h4B) begin miscompares++; $display("FAIL write_resp: got %h expected 4b", tx_log[x0[7:0]]); end
    vectors++;
    if (txn_n - t0 != 1) begin miscompares++; $display("FAIL write_txn_count: got %0d expected 1", txn_n - t0); end
    vectors++;
    if (last_addr !== 32'h0000_1004) begin miscompares++; $display("FAIL write_addr: got %h expected 00001004", last_addr); end
    vectors++;
    if (last_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write_wdata: got %h expected deadbeef", last_wdata); end
    vectors++;
    if (last_wstrb !== 4'hF) begin miscompares++; $display("FAIL write_wstrb: got %h expected f", last_wstrb); end
    vectors++;
    if (valid_cycles - v0 != 3) begin miscompares++; $display("FAIL write_valid_len: got %0d expected 3", valid_cycles - v0); end
  endtask

  task automatic test_read();
    int t0 = txn_n, x0 = tx_n;
    bit ok;
    logic [31:0] got;
    mem_rdata = 32'h1234_5678;
    feed_bytes(72'h52_00_00_20_00, 5);
    wait_tx(x0 + 4, 500, ok);
    repeat (10) @(negedge clk);
    got = {tx_log[x0[7:0]], tx_log[x0[7:0]+8'd1], tx_log[x0[7:0]+8'd2], tx_log[x0[7:0]+8'd3]};
    vectors++;
    if (!ok || tx_n - x0 != 4) begin miscompares++; $display("FAIL read_resp_count: got %0d expected 4", tx_n - x0); end
    vectors++;
    if (got !== 32'h1234_5678) begin miscompares++; $display("FAIL read_resp: got %h expected 12345678", got); end
    vectors++;
    if (txn_n - t0 != 1 || last_addr !== 32'h0000_2000) begin
      miscompares++; $display("FAIL read_addr: got %h (txns %0d) expected 00002000", last_addr, txn_n - t0);
    end
    vectors++;
    if (last_wstrb !== 4'h0) begin miscompares++; $display("FAIL read_wstrb: got %h expected 0", last_wstrb); end
  endtask

  task automatic test_backpressure();
    int x0 = tx_n;
    logic [31:0] exp_word = 32'hA1B2_C3D4;
    logic [31:0] got;
    logic [31:0] held;
    int  unstable;
    bit  seen;
    mem_rdata = 32'hA1B2_C3D4;
    uart_dat_wait = 1'b1;
    feed_bytes(72'h52_00_00_00_40, 5);
    for (int b = 0; b < 4; b++) begin
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (uart_dat_we === 1'b1) begin seen = 1'b1; break; end
      end
      held = uart_dat_di;
      unstable = 0;
      repeat (50) begin
        @(negedge clk);
        if (uart_dat_we !== 1'b1 || uart_dat_di !== held) unstable++;
      end
      vectors++;
      if (!seen || unstable != 0 || held[7:0] !== exp_word[31-8*b -: 8]) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got byte %h unstable %0d expected byte %h held", b, held[7:0], unstable, exp_word[31-8*b -: 8]);
      end
      uart_dat_wait = 1'b0;
      @(negedge clk);
      uart_dat_wait = 1'b1;
    end
    uart_dat_wait = 1'b0;
    repeat (10) @(negedge clk);
    got = {tx_log[x0[7:0]], tx_log[x0[7:0]+8'd1], tx_log[x0[7:0]+8'd2], tx_log[x0[7:0]+8'd3]};
    vectors++;
    if (tx_n - x0 != 4 || got !== 32'hA1B2_C3D4) begin
      miscompares++; $display("FAIL bp_bytes: got %h count %0d expected a1b2c3d4 count 4", got, tx_n - x0);
    end
  endtask

  task automatic test_bad_cmd();
    int x0 = tx_n;
    bit ok;
    feed_bytes(72'h41, 1);
    wait_tx(x0 + 1, 200, ok);
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || tx_n - x0 != 1 || tx_log[x0[7:0]] !== 8'h3F) begin
      miscompares++; $display("FAIL bad_cmd: got %h count %0d expected 3f count 1", tx_log[x0[7:0]], tx_n - x0);
    end
  endtask

  task automatic test_bus_timeout();
    int x0 = tx_n, t0 = txn_n, v0 = valid_cycles;
    bit ok;
    slave_en = 1'b0;
    feed_bytes(72'h52_00_00_00_10, 5);
    wait_tx(x0 + 1, 3000, ok);
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || tx_n - x0 != 1 || tx_log[x0[7:0]] !== 8'h45) begin
      miscompares++; $display("FAIL bus_to_resp: got %h count %0d expected 45 count 1", tx_log[x0[7:0]], tx_n - x0);
    end
    vectors++;
    if (valid_cycles - v0 != 1024 || txn_n != t0) begin
      miscompares++; $display("FAIL bus_to_valid_len: got %0d expected 1024", valid_cycles - v0);
    end
    slave_en = 1'b1;
    // recovery write with low address bits set: they must not reach the bus
    x0 = tx_n;
    t0 = txn_n;
    feed_bytes(72'h57_00_00_00_23_11_22_33_44, 9);
    wait_tx(x0 + 1, 500, ok);
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || tx_log[x0[7:0]] !== 8'h4B || txn_n - t0 != 1) begin
      miscompares++; $display("FAIL recover_resp: got %h txns %0d expected 4b txns 1", tx_log[x0[7:0]], txn_n - t0);
    end
    vectors++;
    if (last_addr !== 32'h0000_0020 || last_wdata !== 32'h1122_3344) begin
      miscompares++; $display("FAIL recover_addr: got %h/%h expected 00000020/11223344", last_addr, last_wdata);
    end
  endtask

  task automatic test_rx_timeout();
    int x0 = tx_n, t0 = txn_n;
    bit ok;
    logic [31:0] got;
    mem_rdata = 32'hCAFE_F00D;
    feed_bytes(72'h57_00_00, 3);
    repeat (RX_TO + 20) @(negedge clk);
    vectors++;
    if (txn_n != t0 || tx_n != x0) begin
      miscompares++; $display("FAIL rxto_silent: got txns %0d resp %0d expected 0 0", txn_n - t0, tx_n - x0);
    end
    feed_bytes(72'h52_00_00_00_08, 5);
    wait_tx(x0 + 4, 500, ok);
    repeat (5) @(negedge clk);
    got = {tx_log[x0[7:0]], tx_log[x0[7:0]+8'd1], tx_log[x0[7:0]+8'd2], tx_log[x0[7:0]+8'd3]};
    vectors++;
    if (!ok || txn_n - t0 != 1 || last_addr !== 32'h0000_0008 || last_wstrb !== 4'h0) begin
      miscompares++; $display("FAIL rxto_read: got addr %h wstrb %h txns %0d expected 00000008 0 1", last_addr, last_wstrb, txn_n - t0);
    end
    vectors++;
    if (got !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rxto_data: got %h expected cafef00d", got); end
  endtask

  task automatic test_reset_mid_bus();
    int x0;
    bit seen = 1'b0;
    bit ok;
    slave_en = 1'b0;
    feed_bytes(72'h52_00_00_00_0C, 5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin seen = 1'b1; break; end
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (!seen || mem_valid !== 1'b1) begin miscompares++; $display("FAIL midbus_pre: got valid %b expected 1", mem_valid); end
    x0 = tx_n;
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (mem_valid !== 1'b0 || uart_dat_we !== 1'b0) begin
      miscompares++; $display("FAIL midbus_drop: got valid %b we %b expected 0 0", mem_valid, uart_dat_we);
    end
    @(negedge clk);
    reset = 1'b0;
    slave_en = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (tx_n != x0 || mem_valid !== 1'b0) begin
      miscompares++; $display("FAIL midbus_quiet: got resp %0d valid %b expected 0 0", tx_n - x0, mem_valid);
    end
    feed_bytes(72'h57_00_00_00_30_55_66_77_88, 9);
    wait_tx(x0 + 1, 500, ok);
    repeat (5) @(negedge clk);
    vectors++;
    if (!ok || tx_log[x0[7:0]] !== 8'h4B || last_addr !== 32'h30 || last_wdata !== 32'h5566_7788) begin
      miscompares++; $display("FAIL midbus_after: got %h addr %h data %h expected 4b 00000030 55667788", tx_log[x0[7:0]], last_addr, last_wdata);
    end
  endtask

  task automatic test_protocol_rules();
    vectors++;
    if (overlap_err != 0 || re_consec_err != 0 || re_empty_err != 0) begin
      miscompares++; $display("FAIL uart_rules: got overlap %0d consec %0d empty %0d expected 0", overlap_err, re_consec_err, re_empty_err);
    end
    vectors++;
    if (stab_err != 0) begin miscompares++; $display("FAIL bus_stable: got %0d changes expected 0", stab_err); end
    vectors++;
    if (rx_rd != rx_wr) begin miscompares++; $display("FAIL rx_drained: got %0d of %0d expected all", rx_rd, rx_wr); end
  endtask

  initial begin
    mem_rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_bad_cmd();
    test_bus_timeout();
    test_rx_timeout();
    test_reset_mid_bus();
    test_protocol_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
